csa_out_arbiter: RTL and testbench
==================================

Name: csa_out_arbiter

Overview:
- Shares one 32-bit output FIFO write port between NUM_CH CSA result channels, each producing 48-bit results.
- Grants one channel at a time, round-robin, and emits each accepted result as three tagged 32-bit words with no interleaving.
- Honours the downstream full flag before every word.
- Sits between the per-channel CSA output stages and the AXI-side 32-bit FIFO.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- AXI_DATA_WIDTH, 32, output word width.
- CSA_OUT_OUT_DATA_WIDTH, 48, per-channel result width; must equal 3*16.
- CH_ID_WIDTH, 3, width of the channel-index tag field.

Ports:
- clk  input  1  single clock for all logic.
- rst_n  input  1  reset: one clock; reset is synchronous and active-low.
- req_valid  input  NUM_CH  per-channel request; held high with stable data until that channel's req_ready pulse.
- req_data  input  NUM_CH*48  channel i data at [i*48 +: 48].
- req_ready  output  NUM_CH  one-cycle accept pulse, one-hot.
- error_full_32  input  1  downstream FIFO full.
- wclk_32  output  1  equals clk.
- wen_32  output  1  registered write enable.
- wdata_32  output  32  registered write data.
- busy  output  1  high when state is not IDLE.
- group_count  output  32  number of completed 3-word groups, wraps at 2^32.

Behaviour:
- Reset (sampled on clk edge with rst_n==0):
  - state=IDLE, rr_ptr=0.
  - wen_32=0, wdata_32=0, req_ready=0, group_count=0, busy=0.
  - Latched data is cleared.
  - Reset mid-group abandons the group. The remaining words are not emitted and no partial count is kept.
- States: IDLE, EMIT0, EMIT1, EMIT2.
- req_ready and wen_32 default to 0 every cycle unless asserted as described below.
- IDLE:
  - If error_full_32==0 and any req_valid is high, grant the first valid channel searching upward from rr_ptr, with modulo NUM_CH wrap.
  - Latch req_data slice and channel index.
  - req_ready[g]<=1, rr_ptr<=(g+1) mod NUM_CH, state<=EMIT0.
  - If error_full_32==1, grant nothing, even if requests are pending.
- EMITk (k=0,1,2):
  - If error_full_32==0: wen_32<=1 and wdata_32<=word k. Advance to EMIT(k+1); EMIT2 returns to IDLE and increments group_count.
  - If error_full_32==1: wen_32<=0, hold state and wdata_32. A stall may last any number of cycles.
- Word k format:
  - [15:0] = data[16*k +: 16].
  - [16+CH_ID_WIDTH-1:16] = channel index.
  - [25:24] = k.
  - All other bits 0.
- Latency with no stall:
  - Grant decided in cycle T; req_ready visible in T+1.
  - wen_32 high in T+2, T+3 and T+4 (words 0, 1, 2).
  - busy is high T+1..T+3, low in T+4.
  - Earliest next grant is decided in T+4, so peak rate is one group per 4 cycles.
- Requester protocol: the requester may drop req_valid any time after seeing req_ready. Because IDLE is not re-entered before T+4, no double grant is possible.
- Simultaneous events:
  - A request arriving in the same cycle as the EMIT2→IDLE transition is not seen until the next IDLE cycle.
  - error_full_32 rising in the same cycle as a grant does not revoke the grant; EMIT0 stalls instead.
- req_valid is ignored while busy. Other channels wait and lose no priority.

Test Plan:
- Single channel 2, data 0xAAAA_5555_1234, full=0 -> req_ready[2] pulse one cycle later; words 0x0002_1234, 0x0102_5555, 0x0202_AAAA on three consecutive wen_32 cycles; group_count=1.
- All 4 channels valid continuously from reset -> grant order 0,1,2,3,0; groups never interleave; 4 cycles per group.
- error_full_32 high for 5 cycles while in EMIT1 -> word0 written, no wen_32 for those 5 cycles, wdata_32 stable, then word1 and word2 follow back-to-back.
- error_full_32=1 in IDLE with requests pending -> no req_ready and no wen_32; after release, grant goes to the channel at rr_ptr.
- rst_n low for 1 cycle during EMIT1 -> next cycle wen_32=0, busy=0, group_count=0; the remaining words are never written.
- Preload group_count to 0xFFFF_FFFF by forcing, then complete one group -> group_count=0.

Source files
------------

// File: rtl/csa_out_arbiter.sv
// csa_out_arbiter
//   Round-robin arbiter that shares one 32-bit FIFO write port between NUM_CH
//   CSA result channels. Each granted 48-bit result is emitted as three tagged
//   32-bit words (low, mid, high halfword) with no interleaving between groups.
//   The downstream full flag is honoured before every word.
//
// Ports
//   clk            clock for all logic
//   rst_n          synchronous active-low reset
//   req_valid      per-channel request, held with stable data until req_ready
//   req_data       channel i result at [i*48 +: 48]
//   req_ready      one-cycle one-hot accept pulse
//   error_full_32  downstream FIFO full
//   wclk_32        FIFO write clock (same as clk)
//   wen_32         registered FIFO write enable
//   wdata_32       registered FIFO write data
//   busy           high while a group is being emitted
//   group_count    completed 3-word groups, wraps at 2^32

module csa_out_arbiter #(
    parameter int unsigned NUM_CH                 = 4,
    parameter int unsigned AXI_DATA_WIDTH         = 32,
    parameter int unsigned CSA_OUT_OUT_DATA_WIDTH = 48,
    parameter int unsigned CH_ID_WIDTH            = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_CH-1:0]                        req_valid,
    input  logic [NUM_CH*CSA_OUT_OUT_DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]                        req_ready,
    input  logic                                     error_full_32,
    output logic                                     wclk_32,
    output logic                                     wen_32,
    output logic [AXI_DATA_WIDTH-1:0]                wdata_32,
    output logic                                     busy,
    output logic [31:0]                              group_count
);

    localparam int unsigned DW = CSA_OUT_OUT_DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StEmit0, StEmit1, StEmit2} state_e;

    state_e                    state_q, state_d;
    logic [CH_ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CH_ID_WIDTH-1:0]    ch_q, ch_d;
    logic [DW-1:0]             data_q, data_d;
    logic [NUM_CH-1:0]         ready_q, ready_d;
    logic                      wen_q, wen_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [31:0]               group_count_q, group_count_d;

    // Grant search results
    logic                      found;
    logic [CH_ID_WIDTH-1:0]    grant_idx;
    logic [NUM_CH-1:0]         grant_onehot;
    logic [DW-1:0]             grant_data;

    // Word currently due for emission
    logic [1:0]                word_k;
    logic [AXI_DATA_WIDTH-1:0] word;

    // Round-robin search: first pass covers channels at or above rr_ptr, the
    // second pass wraps to the channels below it.
    always_comb begin
        found        = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        grant_data   = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            if (!found && req_valid[j] && (j >= int'(rr_ptr_q))) begin
                found           = 1'b1;
                grant_idx       = CH_ID_WIDTH'(j);
                grant_onehot[j] = 1'b1;
                grant_data      = req_data[j*DW +: DW];
            end
        end
        for (int j = 0; j < int'(NUM_CH); j++) begin
            if (!found && req_valid[j]) begin
                found           = 1'b1;
                grant_idx       = CH_ID_WIDTH'(j);
                grant_onehot[j] = 1'b1;
                grant_data      = req_data[j*DW +: DW];
            end
        end
    end

    // Tagged word: [15:0] halfword k, [16 +: CH_ID_WIDTH] channel, [25:24] k
    always_comb begin
        unique case (state_q)
            StEmit1: word_k = 2'd1;
            StEmit2: word_k = 2'd2;
            default: word_k = 2'd0;
        endcase
        word                      = '0;
        word[15:0]                = data_q[int'(word_k)*16 +: 16];
        word[16 +: CH_ID_WIDTH]   = ch_q;
        word[25:24]               = word_k;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        ch_d          = ch_q;
        data_d        = data_q;
        ready_d       = '0;
        wen_d         = 1'b0;
        wdata_d       = wdata_q;
        group_count_d = group_count_q;

        unique case (state_q)
            StIdle: begin
                if (!error_full_32 && found) begin
                    ch_d    = grant_idx;
                    data_d  = grant_data;
                    ready_d = grant_onehot;
                    if (int'(grant_idx) == int'(NUM_CH) - 1) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + 1'b1;
                    end
                    state_d = StEmit0;
                end
            end
            StEmit0, StEmit1, StEmit2: begin
                // A stall holds state and wdata; wen stays low
                if (!error_full_32) begin
                    wen_d   = 1'b1;
                    wdata_d = word;
                    unique case (state_q)
                        StEmit0: state_d = StEmit1;
                        StEmit1: state_d = StEmit2;
                        default: begin
                            state_d       = StIdle;
                            group_count_d = group_count_q + 32'd1;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            ch_q          <= '0;
            data_q        <= '0;
            ready_q       <= '0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            group_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            ch_q          <= ch_d;
            data_q        <= data_d;
            ready_q       <= ready_d;
            wen_q         <= wen_d;
            wdata_q       <= wdata_d;
            group_count_q <= group_count_d;
        end
    end

    assign wclk_32     = clk;
    assign req_ready   = ready_q;
    assign wen_32      = wen_q;
    assign wdata_32    = wdata_q;
    assign busy        = (state_q != StIdle);
    assign group_count = group_count_q;

endmodule

// File: tb/tb_csa_out_arbiter.sv
// Testbench for csa_out_arbiter: directed vector table, round-robin order
// sequence, randomized traffic against a transaction-level model, and
// group_count wrap.

module tb_csa_out_arbiter;

    localparam int N  = 4;
    localparam int DW = 48;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              error_full_32;
    logic              wclk_32;
    logic              wen_32;
    logic [31:0]       wdata_32;
    logic              busy;
    logic [31:0]       group_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_out_arbiter #(
        .NUM_CH                 (N),
        .AXI_DATA_WIDTH         (32),
        .CSA_OUT_OUT_DATA_WIDTH (DW),
        .CH_ID_WIDTH            (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .error_full_32 (error_full_32),
        .wclk_32       (wclk_32),
        .wen_32        (wen_32),
        .wdata_32      (wdata_32),
        .busy          (busy),
        .group_count   (group_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        full;
        logic [3:0]  valid;
        logic [3:0]  e_ready;
        logic        e_wen;
        logic [31:0] e_wdata;
        logic        e_busy;
        logic [31:0] e_gc;
    } vec_t;

    vec_t tbl[$];

    // ---------------- reference model ----------------
    // Tracks the words still owed for the current group; a grant queues three.
    int          m_left;
    int          m_rr;
    int          m_ch;
    logic [47:0] m_data;
    logic [31:0] m_gc;
    logic [3:0]  e_ready;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic        e_busy;

    task automatic model_step();
        int          g;
        int          k;
        logic [47:0] sh;
        e_ready = '0;
        e_wen   = 1'b0;
        if (!rst_n) begin
            m_left  = 0;
            m_rr    = 0;
            m_ch    = 0;
            m_data  = '0;
            m_gc    = '0;
            e_wdata = '0;
        end else if (m_left == 0) begin
            if (!error_full_32 && req_valid != 0) begin
                g = -1;
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && req_valid[(m_rr + i) % N]) g = (m_rr + i) % N;
                end
                e_ready[g] = 1'b1;
                m_ch   = g;
                m_data = req_data[g*DW +: DW];
                m_rr   = (g + 1) % N;
                m_left = 3;
            end
        end else if (!error_full_32) begin
            k       = 3 - m_left;
            sh      = m_data >> (16 * k);
            e_wen   = 1'b1;
            e_wdata = {6'd0, 2'(k), 5'd0, 3'(m_ch), sh[15:0]};
            m_left--;
            if (m_left == 0) m_gc = m_gc + 32'd1;
        end
        e_busy = (m_left != 0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ready"}, 64'(req_ready), 64'(e_ready));
        check({tag, "_wen"},   64'(wen_32),    64'(e_wen));
        check({tag, "_wdata"}, 64'(wdata_32),  64'(e_wdata));
        check({tag, "_busy"},  64'(busy),      64'(e_busy));
        check({tag, "_gc"},    64'(group_count), 64'(m_gc));
    endtask

    int grant_ch[$];
    int grant_cyc[$];

    initial begin
        rst_n         = 1'b0;
        error_full_32 = 1'b0;
        req_valid     = '0;
        req_data      = {48'h3C3C_3B3B_3A3A, 48'hAAAA_5555_1234,
                         48'h1C1C_1B1B_1A1A, 48'h0C0C_0B0B_0A0A};

        //             rst  full valid    ready    wen   wdata          busy  gc
        tbl.push_back('{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0100, 4'b0100, 1'b0, 32'h0000_0000, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0002_1234, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0102_5555, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0202_AAAA, 1'b0, 32'd1});
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 32'h0202_AAAA, 1'b0, 32'd1});
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 32'h0202_AAAA, 1'b0, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b1111, 4'b1000, 1'b0, 32'h0202_AAAA, 1'b1, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0111, 4'b0000, 1'b1, 32'h0003_3A3A, 1'b1, 32'd1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b1, 1'b1, 4'b0111, 4'b0000, 1'b0, 32'h0003_3A3A, 1'b1, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0111, 4'b0000, 1'b1, 32'h0103_3B3B, 1'b1, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0111, 4'b0000, 1'b1, 32'h0203_3C3C, 1'b0, 32'd2});
        tbl.push_back('{1'b1, 1'b0, 4'b0111, 4'b0001, 1'b0, 32'h0203_3C3C, 1'b1, 32'd2});
        tbl.push_back('{1'b1, 1'b0, 4'b0110, 4'b0000, 1'b1, 32'h0000_0A0A, 1'b1, 32'd2});
        tbl.push_back('{1'b0, 1'b0, 4'b0110, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0, 32'h0000_0000, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0001_1A1A, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0101_1B1B, 1'b1, 32'd0});
        tbl.push_back('{1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 32'h0201_1C1C, 1'b0, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 32'h0201_1C1C, 1'b1, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0000_0A0A, 1'b1, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0100_0B0B, 1'b1, 32'd1});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 32'h0200_0C0C, 1'b0, 32'd2});

        foreach (tbl[r]) begin
            rst_n         = tbl[r].rst;
            error_full_32 = tbl[r].full;
            req_valid     = tbl[r].valid;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_ready", r), 64'(req_ready),   64'(tbl[r].e_ready));
            check($sformatf("vec%0d_wen", r),   64'(wen_32),      64'(tbl[r].e_wen));
            check($sformatf("vec%0d_wdata", r), 64'(wdata_32),    64'(tbl[r].e_wdata));
            check($sformatf("vec%0d_busy", r),  64'(busy),        64'(tbl[r].e_busy));
            check($sformatf("vec%0d_gc", r),    64'(group_count), 64'(tbl[r].e_gc));
        end

        // ---------------- all channels continuously valid ----------------
        rst_n = 1'b0; req_valid = '0; error_full_32 = 1'b0;
        cycle("rr_rst");
        rst_n = 1'b1; req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            cycle("rr");
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    grant_ch.push_back(i);
                    grant_cyc.push_back(c);
                end
            end
        end
        check("rr_count_ge5", 64'(grant_ch.size() >= 5), 64'd1);
        if (grant_ch.size() >= 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 64'(grant_ch[i]), 64'(i % N));
            for (int i = 1; i < 5; i++)
                check($sformatf("rr_spacing%0d", i), 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd4);
        end

        // ---------------- randomized traffic ----------------
        rst_n = 1'b0; req_valid = '0;
        cycle("rand_rst");
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else req_data[i*DW +: DW] = DW'({$urandom(), $urandom()});
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'({$urandom(), $urandom()});
                end
            end
            error_full_32 = ($urandom_range(0, 3) == 0);
            rst_n         = ($urandom_range(0, 199) != 0);
            cycle("rand");
        end

        // ---------------- group_count wrap ----------------
        rst_n = 1'b0; req_valid = '0; error_full_32 = 1'b0;
        cycle("wrap_rst");
        rst_n = 1'b1;
        force dut.group_count_d = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.group_count_d;
        m_gc = 32'hFFFF_FFFF;
        check("wrap_preload", 64'(group_count), 64'h0000_0000_FFFF_FFFF);
        req_valid = 4'b0001;
        cycle("wrap");
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle("wrap");
        check("wrap_zero", 64'(group_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
